// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer slice.
//   - 4-bit request opcode constants
//   - 3-bit alu_control codes driven to the external combinational ALU
//   - FSM state type and branch-kind type
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_INV = 4'b0010;
  localparam logic [3:0] OP_LSL = 4'b0011;
  localparam logic [3:0] OP_LSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LD  = 4'b1000;
  localparam logic [3:0] OP_ST  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INV = 3'b010;
  localparam logic [2:0] ALU_LSL = 3'b011;
  localparam logic [2:0] ALU_LSR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational request-opcode decoder.
// Ports:
//   opcode_i      in  4  request opcode
//   alu_control_o out 3  ALU operation code (ADD for LD/ST address add)
//   illegal_o     out 1  opcode not recognised (control falls back to ADD)
//   branch_o      out 2  branch kind, only when ALU_SEQ_CTRL_BRANCH_EN is defined
// Macro ALU_SEQ_CTRL_BRANCH_EN: adds BEQ/BNE (decoded as SUB).
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_control_o,
`ifdef ALU_SEQ_CTRL_BRANCH_EN
  output branch_t    branch_o,
`endif
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
    branch_o      = BR_NONE;
`endif
    case (opcode_i)
      OP_ADD: alu_control_o = ALU_ADD;
      OP_SUB: alu_control_o = ALU_SUB;
      OP_INV: alu_control_o = ALU_INV;
      OP_LSL: alu_control_o = ALU_LSL;
      OP_LSR: alu_control_o = ALU_LSR;
      OP_AND: alu_control_o = ALU_AND;
      OP_OR:  alu_control_o = ALU_OR;
      OP_SLT: alu_control_o = ALU_SLT;
      OP_LD,
      OP_ST:  alu_control_o = ALU_ADD;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
      OP_BEQ: begin
        alu_control_o = ALU_SUB;
        branch_o      = BR_EQ;
      end
      OP_BNE: begin
        alu_control_o = ALU_SUB;
        branch_o      = BR_NE;
      end
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one request at a time through an external
// combinational ALU (IDLE -> EXEC -> DONE) and holds the result until
// the consumer accepts it.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake (ready only in IDLE)
//   in_opcode, in_a, in_b      request opcode and operands
//   alu_x, alu_y, alu_control  drive to the external ALU
//   alu_res, alu_zero          ALU result and zero flag (same cycle)
//   out_valid/out_ready        result handshake
//   out_res, out_zero          registered result and zero flag
//   out_illegal                result came from an unrecognised opcode
//   op_count                   saturating count of completed operations
//   out_branch_taken           only with ALU_SEQ_CTRL_BRANCH_EN
// Macro ALU_SEQ_CTRL_BRANCH_EN: enables BEQ/BNE and out_branch_taken.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [2:0]        alu_control,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic              out_zero,
  output logic              out_illegal,
`ifdef ALU_SEQ_CTRL_BRANCH_EN
  output logic              out_branch_taken,
`endif
  output logic [15:0]       op_count
);

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              ill_q, ill_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        dec_ctrl;
  logic              dec_ill;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
  branch_t           dec_br;
  logic              br_q, br_d;
`endif

  // Decode the captured opcode, so the decode is stable for the whole EXEC cycle.
  alu_op_decode u_dec (
    .opcode_i      (op_q),
    .alu_control_o (dec_ctrl),
`ifdef ALU_SEQ_CTRL_BRANCH_EN
    .branch_o      (dec_br),
`endif
    .illegal_o     (dec_ill)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    zero_d      = zero_q;
    ill_d       = ill_q;
    cnt_d       = cnt_q;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
    br_d        = br_q;
`endif
    alu_control = ALU_ADD;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_opcode;
          a_d     = in_a;
          b_d     = in_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_control = dec_ctrl;
        res_d       = alu_res;
        zero_d      = alu_zero;
        ill_d       = dec_ill;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
        case (dec_br)
          BR_EQ:   br_d = alu_zero;
          BR_NE:   br_d = ~alu_zero;
          default: br_d = 1'b0;
        endcase
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
      br_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
      br_q    <= br_d;
`endif
    end
  end

  // rst is folded in so ready drops in the same cycle reset is raised.
  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = (state_q == DONE);
  assign alu_x       = a_q;
  assign alu_y       = b_q;
  assign out_res     = res_q;
  assign out_zero    = zero_q;
  assign out_illegal = ill_q;
  assign op_count    = cnt_q;
`ifdef ALU_SEQ_CTRL_BRANCH_EN
  assign out_branch_taken = br_q;
`endif

endmodule
